wb_arbiter2: RTL and testbench
==============================

// Module: wb_arbiter2
// PURPOSE
//  Two-master arbiter for the 8-bit Wishbone debug/loader bus into mainboard (VDP/ROM/GROM windows).
//  Shares the single slave port between a host port (m0) and a loader/debug port (m1), one cycle at a time.
//  Adds a no-ack watchdog: unmapped windows (wb_adr_i[0:7] > 8'h02) never ack, so they must not hang a master.
// PARAMETERS
//  adr_bits      24   address width; all ports carry [0:adr_bits-1]
//  timeout_cyc   255  cycles of unacked slave strobe before err is forced (1..65535)
// PORTS
//  clk             in   1         system clock; one clock domain only
//  reset           in   1         asynchronous, active-high
//  mN_adr_i        in   adr_bits  master N address (N = 0,1)
//  mN_dat_i        in   8         master N write data
//  mN_dat_o        out  8         master N read data
//  mN_we_i         in   1         master N write enable
//  mN_sel_i        in   1         master N byte select
//  mN_stb_i        in   1         master N strobe
//  mN_cyc_i        in   1         master N cycle (bus request/hold)
//  mN_ack_o        out  1         master N ack
//  mN_err_o        out  1         master N error (watchdog timeout)
//  s_adr_o,s_dat_o,s_we_o,s_sel_o,s_stb_o,s_cyc_o   out        to mainboard wb_*_i
//  s_dat_i,s_ack_i                                  in         from mainboard wb_dat_o/wb_ack_o
//  grant_o         out  2         [0]=m0 owns bus, [1]=m1 owns bus; never both
//  timeout_cnt_o   out  8         saturating count of watchdog errors since reset
// BEHAVIOUR
//  Reset (async): state IDLE, last_grant=m1, grant_o=00, all ack/err=0, s_cyc/s_stb=0, counters=0.
//  FSM states: IDLE, OWN0, OWN1; grant registered.
//   IDLE: any mN_cyc_i=1 -> OWNN next edge; both -> master != last_grant (round robin); after reset m0 wins.
//   OWNN: held while mN_cyc_i=1; mN_cyc_i=0 -> IDLE next edge, last_grant<=N. No preemption.
//  Grant latency: request in IDLE is visible on s_* 1 cycle later; ownership change costs >=1 IDLE cycle.
//  Slave side (combinational from owner): s_adr/dat/we/sel = owner's; s_cyc=owner cyc; s_stb=owner stb & ~to_hit.
//   IDLE: s_cyc=s_stb=0, s_adr/s_dat=0.
//  Return path: owner mN_ack_o = s_ack_i & mN_cyc_i & mN_stb_i; mN_dat_o = s_dat_i.
//   Non-owner: ack=err=0, dat_o=8'h00.
//  Watchdog: wd_cnt (16 bit) clears when ~s_stb_o or s_ack_i, else increments each cycle.
//   to_hit = (wd_cnt == timeout_cyc-1) & ~s_ack_i: owner err_o=1 for exactly that cycle, ack_o=0, dat_o=8'hff.
//   wd_cnt clears on the next edge; timeout_cnt_o increments, saturating at 8'hff.
//   ack and timeout in the same cycle: ack wins, no err.
//  Owner drops cyc mid-transfer: s_cyc/s_stb drop the same cycle; any late s_ack_i is discarded; wd_cnt clears.
//  Reset mid-transfer: immediate return to reset values; slave sees stb/cyc drop asynchronously.
// STRUCTURE
//  Package mega99_wb_pkg: arb_state_t {IDLE,OWN0,OWN1}; M0/M1 index constants; WB_DAT_BITS=8; default TIMEOUT.
//  Sub-module wb_watchdog (counter, to_hit, saturating timeout_cnt), instantiated once; FSM and muxing stay top-level.
// TESTING
//  1 m0 single read, slave acks after 3 cycles, data 8'h5a -> grant_o=01 one cycle after cyc; m0_ack one cycle; m0_dat_o=8'h5a.
//  2 m0,m1 cyc rise same cycle after reset -> m0 first; m0 drops cyc; then m1 granted after one IDLE cycle; repeat -> m1 first.
//  3 m1 reads adr 24'h030000, no slave ack, timeout_cyc=4 -> m1_err_o high exactly on 4th strobe cycle.
//    Same cycle: m1_dat_o=8'hff, s_stb_o=0; timeout_cnt_o=1.
//  4 m0 holds bus (burst of 3 writes, cyc held) while m1 requests -> m1 ack/err stay 0; m1 granted only after m0 drops cyc.
//  5 reset asserted while owner stb high mid-wait -> s_cyc/s_stb, grant_o, timeout_cnt_o all 0 before next edge.
//  6 s_ack_i arrives on watchdog terminal cycle -> ack delivered, err=0, timeout_cnt_o unchanged.

Source files
------------

// File: rtl/mega99_wb_pkg.sv
// Shared types and constants for the mega99 8-bit Wishbone debug/loader bus.
//   arb_state_t : arbiter ownership state (IDLE, OWN0, OWN1)
//   M0 / M1     : master indices, also used as grant_o bit positions and last-grant encoding
//   WB_DAT_BITS : data bus width
//   TIMEOUT     : default watchdog timeout in cycles
package mega99_wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  localparam int unsigned M0          = 0;
  localparam int unsigned M1          = 1;
  localparam int unsigned WB_DAT_BITS = 8;
  localparam int unsigned TIMEOUT     = 255;
  localparam int unsigned WD_CNT_BITS = 16;
  localparam int unsigned TO_CNT_BITS = 8;

  // One-hot grant vector for a given ownership state.
  function automatic logic [1:0] grant_of(arb_state_t st);
    logic [1:0] g;
    g = 2'b00;
    if (st == OWN0) g[M0] = 1'b1;
    if (st == OWN1) g[M1] = 1'b1;
    return g;
  endfunction

endpackage

// File: rtl/wb_watchdog.sv
// No-ack watchdog for the shared slave port.
// Counts consecutive cycles of an unacknowledged owner strobe; on the terminal cycle it raises
// to_hit (which the top uses to kill the slave strobe and signal err), then restarts.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   stb          : raw owner strobe (owner cyc & stb, before to_hit masking)
//   ack          : slave ack
//   to_hit       : terminal cycle reached without ack (combinational)
//   timeout_cnt  : saturating count of watchdog hits since reset
module wb_watchdog
  import mega99_wb_pkg::*;
#(
  parameter int unsigned timeout_cyc = TIMEOUT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stb,
  input  logic                   ack,
  output logic                   to_hit,
  output logic [TO_CNT_BITS-1:0] timeout_cnt
);

  localparam logic [WD_CNT_BITS-1:0] TermCnt = WD_CNT_BITS'(timeout_cyc - 1);
  localparam logic [TO_CNT_BITS-1:0] CntMax  = '1;

  logic [WD_CNT_BITS-1:0] wd_cnt_q, wd_cnt_d;
  logic [TO_CNT_BITS-1:0] to_cnt_q, to_cnt_d;

  // An ack on the terminal cycle wins over the timeout.
  assign to_hit = stb & ~ack & (wd_cnt_q == TermCnt);

  always_comb begin
    wd_cnt_d = wd_cnt_q + 1'b1;
    // The visible slave strobe is low on a hit, so the count restarts just as for an idle strobe.
    if (!stb || ack || to_hit) begin
      wd_cnt_d = '0;
    end
  end

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (to_hit && (to_cnt_q != CntMax)) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt_q <= '0;
      to_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  assign timeout_cnt = to_cnt_q;

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master arbiter for the 8-bit Wishbone debug/loader bus into mainboard.
// m0 (host) and m1 (loader/debug) share one slave port; ownership is granted from IDLE,
// round-robin on simultaneous requests, held until the owner drops cyc (no preemption).
// A watchdog forces err on the owner when the slave never acks (unmapped windows).
// Ports:
//   clk, reset                  : clock, asynchronous active-high reset
//   mN_adr/dat/we/sel/stb/cyc_i : master N request side
//   mN_dat/ack/err_o            : master N return side (zero when not owner)
//   s_adr/dat/we/sel/stb/cyc_o  : slave request side, combinational from the owner
//   s_dat_i, s_ack_i            : slave return side
//   grant_o                     : registered one-hot owner, [0]=m0, [1]=m1
//   timeout_cnt_o               : saturating count of watchdog errors
module wb_arbiter2
  import mega99_wb_pkg::*;
#(
  parameter int unsigned adr_bits    = 24,
  parameter int unsigned timeout_cyc = TIMEOUT
) (
  input  logic                   clk,
  input  logic                   reset,
  // master 0
  input  logic [0:adr_bits-1]    m0_adr_i,
  input  logic [WB_DAT_BITS-1:0] m0_dat_i,
  output logic [WB_DAT_BITS-1:0] m0_dat_o,
  input  logic                   m0_we_i,
  input  logic                   m0_sel_i,
  input  logic                   m0_stb_i,
  input  logic                   m0_cyc_i,
  output logic                   m0_ack_o,
  output logic                   m0_err_o,
  // master 1
  input  logic [0:adr_bits-1]    m1_adr_i,
  input  logic [WB_DAT_BITS-1:0] m1_dat_i,
  output logic [WB_DAT_BITS-1:0] m1_dat_o,
  input  logic                   m1_we_i,
  input  logic                   m1_sel_i,
  input  logic                   m1_stb_i,
  input  logic                   m1_cyc_i,
  output logic                   m1_ack_o,
  output logic                   m1_err_o,
  // slave
  output logic [0:adr_bits-1]    s_adr_o,
  output logic [WB_DAT_BITS-1:0] s_dat_o,
  output logic                   s_we_o,
  output logic                   s_sel_o,
  output logic                   s_stb_o,
  output logic                   s_cyc_o,
  input  logic [WB_DAT_BITS-1:0] s_dat_i,
  input  logic                   s_ack_i,
  // status
  output logic [1:0]             grant_o,
  output logic [7:0]             timeout_cnt_o
);

  localparam logic [WB_DAT_BITS-1:0] DatErr = '1;

  arb_state_t state_q;
  logic       last_q;   // last master that released the bus (0 = m0, 1 = m1)
  logic [1:0] grant_q;

  logic own0, own1;
  logic owner_stb;      // owner cyc & stb, before watchdog masking
  logic to_hit;

  // ---------------------------------------------------------------------------
  // Ownership FSM with registered grant
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'(M1);
      grant_q <= 2'b00;
    end else begin
      unique case (state_q)
        IDLE: begin
          // m0 wins unless m1 also requests and m0 was served last.
          if (m0_cyc_i && (!m1_cyc_i || (last_q == 1'(M1)))) begin
            state_q <= OWN0;
            grant_q <= grant_of(OWN0);
          end else if (m1_cyc_i) begin
            state_q <= OWN1;
            grant_q <= grant_of(OWN1);
          end
        end
        OWN0: begin
          if (!m0_cyc_i) begin
            state_q <= IDLE;
            grant_q <= grant_of(IDLE);
            last_q  <= 1'(M0);
          end
        end
        OWN1: begin
          if (!m1_cyc_i) begin
            state_q <= IDLE;
            grant_q <= grant_of(IDLE);
            last_q  <= 1'(M1);
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= grant_of(IDLE);
        end
      endcase
    end
  end

  assign grant_o = grant_q;
  assign own0    = (state_q == OWN0);
  assign own1    = (state_q == OWN1);

  // ---------------------------------------------------------------------------
  // Slave-side mux; follows the owner's cyc combinationally so a dropped cyc
  // (or an async reset) removes the request from the slave in the same cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    s_adr_o   = '0;
    s_dat_o   = '0;
    s_we_o    = 1'b0;
    s_sel_o   = 1'b0;
    s_cyc_o   = 1'b0;
    owner_stb = 1'b0;
    if (own0) begin
      s_adr_o   = m0_adr_i;
      s_dat_o   = m0_dat_i;
      s_we_o    = m0_we_i;
      s_sel_o   = m0_sel_i;
      s_cyc_o   = m0_cyc_i;
      owner_stb = m0_cyc_i & m0_stb_i;
    end else if (own1) begin
      s_adr_o   = m1_adr_i;
      s_dat_o   = m1_dat_i;
      s_we_o    = m1_we_i;
      s_sel_o   = m1_sel_i;
      s_cyc_o   = m1_cyc_i;
      owner_stb = m1_cyc_i & m1_stb_i;
    end
  end

  assign s_stb_o = owner_stb & ~to_hit;

  // ---------------------------------------------------------------------------
  // Return path; non-owner sees all zeros, the owner sees 8'hff on a timeout.
  // ---------------------------------------------------------------------------
  always_comb begin
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m0_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    m1_dat_o = '0;
    if (own0) begin
      m0_ack_o = s_ack_i & m0_cyc_i & m0_stb_i;
      m0_err_o = to_hit;
      m0_dat_o = to_hit ? DatErr : s_dat_i;
    end else if (own1) begin
      m1_ack_o = s_ack_i & m1_cyc_i & m1_stb_i;
      m1_err_o = to_hit;
      m1_dat_o = to_hit ? DatErr : s_dat_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  wb_watchdog #(
    .timeout_cyc(timeout_cyc)
  ) u_watchdog (
    .clk        (clk),
    .reset      (reset),
    .stb        (owner_stb),
    .ack        (s_ack_i),
    .to_hit     (to_hit),
    .timeout_cnt(timeout_cnt_o)
  );

endmodule

// File: tb/tb_wb_arbiter2.sv
module tb_wb_arbiter2;

  logic        clk = 1'b0;
  logic        reset;
  logic [0:23] m0_adr_i, m1_adr_i, s_adr_o;
  logic [7:0]  m0_dat_i, m0_dat_o, m1_dat_i, m1_dat_o, s_dat_o, s_dat_i;
  logic        m0_we_i, m0_sel_i, m0_stb_i, m0_cyc_i, m0_ack_o, m0_err_o;
  logic        m1_we_i, m1_sel_i, m1_stb_i, m1_cyc_i, m1_ack_o, m1_err_o;
  logic        s_we_o, s_sel_o, s_stb_o, s_cyc_o, s_ack_i;
  logic [1:0]  grant_o;
  logic [7:0]  timeout_cnt_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_arbiter2 #(
    .adr_bits   (24),
    .timeout_cyc(4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .m0_adr_i     (m0_adr_i),
    .m0_dat_i     (m0_dat_i),
    .m0_dat_o     (m0_dat_o),
    .m0_we_i      (m0_we_i),
    .m0_sel_i     (m0_sel_i),
    .m0_stb_i     (m0_stb_i),
    .m0_cyc_i     (m0_cyc_i),
    .m0_ack_o     (m0_ack_o),
    .m0_err_o     (m0_err_o),
    .m1_adr_i     (m1_adr_i),
    .m1_dat_i     (m1_dat_i),
    .m1_dat_o     (m1_dat_o),
    .m1_we_i      (m1_we_i),
    .m1_sel_i     (m1_sel_i),
    .m1_stb_i     (m1_stb_i),
    .m1_cyc_i     (m1_cyc_i),
    .m1_ack_o     (m1_ack_o),
    .m1_err_o     (m1_err_o),
    .s_adr_o      (s_adr_o),
    .s_dat_o      (s_dat_o),
    .s_we_o       (s_we_o),
    .s_sel_o      (s_sel_o),
    .s_stb_o      (s_stb_o),
    .s_cyc_o      (s_cyc_o),
    .s_dat_i      (s_dat_i),
    .s_ack_i      (s_ack_i),
    .grant_o      (grant_o),
    .timeout_cnt_o(timeout_cnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Move 1 time unit past the next rising edge; inputs are driven and outputs checked there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after driving inputs.
  task automatic settle();
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    m0_adr_i = '0; m0_dat_i = '0; m0_we_i = 0; m0_sel_i = 0; m0_stb_i = 0; m0_cyc_i = 0;
    m1_adr_i = '0; m1_dat_i = '0; m1_we_i = 0; m1_sel_i = 0; m1_stb_i = 0; m1_cyc_i = 0;
    s_dat_i  = '0; s_ack_i = 0;
    tick(); tick();
    chk("rst_grant", 32'(grant_o), 32'h0);
    chk("rst_s_cyc", 32'(s_cyc_o), 32'h0);
    chk("rst_s_stb", 32'(s_stb_o), 32'h0);
    chk("rst_tocnt", 32'(timeout_cnt_o), 32'h0);
    chk("rst_acks", 32'({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}), 32'h0);
    reset = 1'b0;
    tick();

    // ---- 1: m0 single read, ack in 3rd strobe cycle, data 5a ----
    m0_adr_i = 24'h010010; m0_sel_i = 1; m0_stb_i = 1; m0_cyc_i = 1;
    settle();
    chk("t1_idle_grant", 32'(grant_o), 32'h0);
    chk("t1_idle_scyc", 32'(s_cyc_o), 32'h0);
    tick();
    chk("t1_grant", 32'(grant_o), 32'h1);
    chk("t1_scyc", 32'(s_cyc_o), 32'h1);
    chk("t1_sstb", 32'(s_stb_o), 32'h1);
    chk("t1_sadr", 32'(s_adr_o), 32'h010010);
    chk("t1_m1_grant_dat", 32'(m1_dat_o), 32'h0);
    tick();
    chk("t1_noack", 32'(m0_ack_o), 32'h0);
    tick();
    s_ack_i = 1; s_dat_i = 8'h5a;
    settle();
    chk("t1_ack", 32'(m0_ack_o), 32'h1);
    chk("t1_dat", 32'(m0_dat_o), 32'h5a);
    chk("t1_err", 32'(m0_err_o), 32'h0);
    tick();
    s_ack_i = 0; m0_stb_i = 0; m0_cyc_i = 0;
    settle();
    chk("t1_ack_one", 32'(m0_ack_o), 32'h0);
    chk("t1_drop_scyc", 32'(s_cyc_o), 32'h0);
    tick();
    chk("t1_release", 32'(grant_o), 32'h0);

    // ---- 3: m1 reads unmapped window, no ack, timeout 4 ----
    m1_adr_i = 24'h030000; m1_sel_i = 1; m1_stb_i = 1; m1_cyc_i = 1; s_dat_i = 8'h33;
    tick();  // strobe cycle 1
    chk("t3_grant", 32'(grant_o), 32'h2);
    chk("t3_sadr", 32'(s_adr_o), 32'h030000);
    chk("t3_err1", 32'(m1_err_o), 32'h0);
    tick();  // 2
    tick();  // 3
    chk("t3_err3", 32'(m1_err_o), 32'h0);
    chk("t3_stb3", 32'(s_stb_o), 32'h1);
    tick();  // 4
    chk("t3_err4", 32'(m1_err_o), 32'h1);
    chk("t3_dat_ff", 32'(m1_dat_o), 32'hff);
    chk("t3_sstb_kill", 32'(s_stb_o), 32'h0);
    chk("t3_scyc_held", 32'(s_cyc_o), 32'h1);
    chk("t3_ack0", 32'(m1_ack_o), 32'h0);
    tick();  // watchdog restarted
    chk("t3_err_once", 32'(m1_err_o), 32'h0);
    chk("t3_tocnt", 32'(timeout_cnt_o), 32'h1);
    chk("t3_sstb_back", 32'(s_stb_o), 32'h1);
    chk("t3_dat_pass", 32'(m1_dat_o), 32'h33);
    tick();

    // ---- 5: async reset with owner strobe pending ----
    reset = 1'b1;
    settle();
    chk("t5_scyc", 32'(s_cyc_o), 32'h0);
    chk("t5_sstb", 32'(s_stb_o), 32'h0);
    chk("t5_grant", 32'(grant_o), 32'h0);
    chk("t5_tocnt", 32'(timeout_cnt_o), 32'h0);
    m1_stb_i = 0; m1_cyc_i = 0;
    tick();
    reset = 1'b0;
    tick();

    // ---- 2: round robin ----
    m0_cyc_i = 1; m1_cyc_i = 1;
    tick();
    chk("t2_first_m0", 32'(grant_o), 32'h1);
    m0_cyc_i = 0;
    tick();
    chk("t2_idle_gap", 32'(grant_o), 32'h0);
    tick();
    chk("t2_then_m1", 32'(grant_o), 32'h2);
    m0_cyc_i = 1;   // request while m1 holds
    tick();
    chk("t2_no_preempt", 32'(grant_o), 32'h2);
    m1_cyc_i = 0;
    tick();
    chk("t2_idle_gap2", 32'(grant_o), 32'h0);
    tick();
    chk("t2_m0_again", 32'(grant_o), 32'h1);
    m0_cyc_i = 0;
    tick();
    m0_cyc_i = 1; m1_cyc_i = 1;  // m0 served last
    tick();
    chk("t2_repeat_m1", 32'(grant_o), 32'h2);
    m0_cyc_i = 0; m1_cyc_i = 0;
    tick();
    tick();

    // ---- 4: m0 burst of 3 writes while m1 waits ----
    m0_adr_i = 24'h000100; m0_we_i = 1; m0_stb_i = 1; m0_cyc_i = 1; m0_dat_i = 8'ha1;
    tick();
    chk("t4_grant", 32'(grant_o), 32'h1);
    m1_stb_i = 1; m1_cyc_i = 1; s_ack_i = 1; s_dat_i = 8'h44;
    settle();
    chk("t4_w1_ack", 32'(m0_ack_o), 32'h1);
    chk("t4_w1_sdat", 32'(s_dat_o), 32'ha1);
    chk("t4_w1_swe", 32'(s_we_o), 32'h1);
    chk("t4_w1_m1", 32'({m1_ack_o, m1_err_o, m1_dat_o}), 32'h0);
    tick();
    m0_dat_i = 8'ha2;
    settle();
    chk("t4_w2_sdat", 32'(s_dat_o), 32'ha2);
    chk("t4_w2_m1", 32'({m1_ack_o, m1_err_o}), 32'h0);
    tick();
    m0_dat_i = 8'ha3;
    settle();
    chk("t4_w3_ack", 32'(m0_ack_o), 32'h1);
    chk("t4_w3_m1", 32'({m1_ack_o, m1_err_o}), 32'h0);
    tick();
    s_ack_i = 0;
    chk("t4_hold", 32'(grant_o), 32'h1);
    m0_stb_i = 0; m0_cyc_i = 0; m0_we_i = 0;
    tick();
    chk("t4_idle", 32'(grant_o), 32'h0);
    tick();  // m1 owns: strobe cycle 1 (watchdog count 0)
    chk("t4_m1_granted", 32'(grant_o), 32'h2);

    // ---- 6: ack on watchdog terminal cycle ----
    tick();  // 2
    tick();  // 3
    tick();  // 4: terminal cycle
    s_ack_i = 1; s_dat_i = 8'h77;
    settle();
    chk("t6_ack", 32'(m1_ack_o), 32'h1);
    chk("t6_err", 32'(m1_err_o), 32'h0);
    chk("t6_dat", 32'(m1_dat_o), 32'h77);
    chk("t6_sstb", 32'(s_stb_o), 32'h1);
    tick();
    s_ack_i = 0;
    settle();
    chk("t6_tocnt", 32'(timeout_cnt_o), 32'h0);
    chk("t6_err_after", 32'(m1_err_o), 32'h0);
    tick();
    tick();
    chk("t6_restart", 32'(m1_err_o), 32'h0);
    m1_stb_i = 0; m1_cyc_i = 0;
    tick();
    tick();
    chk("t6_release", 32'(grant_o), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
